// File: rtl/conv_host_ctrl_if.sv
// Signal bundle between the convolution host controller and its surroundings:
// input word stream, input-SRAM write port, engine run/busy, output-SRAM read port, result stream.
interface conv_host_ctrl_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [AW-1:0] host_sram_write_address;
    logic [DW-1:0] host_sram_write_data;
    logic          host_sram_write_enable;
    logic          dut_run;
    logic          dut_busy;
    logic [AW-1:0] host_osram_read_address;
    logic [DW-1:0] osram_host_read_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic          err;

    modport master (
        input  in_valid, in_data, in_last, dut_busy, osram_host_read_data, out_ready,
        output in_ready, host_sram_write_address, host_sram_write_data, host_sram_write_enable,
        output dut_run, host_osram_read_address, out_valid, out_data, out_last, done, err
    );

    modport slave (
        output in_valid, in_data, in_last, dut_busy, osram_host_read_data, out_ready,
        input  in_ready, host_sram_write_address, host_sram_write_data, host_sram_write_enable,
        input  dut_run, host_osram_read_address, out_valid, out_data, out_last, done, err
    );
endinterface

// File: rtl/conv_host_ctrl.sv
// Host driver for the 3x3 convolution engine: packs matrices into input SRAM, kicks the
// engine, then streams the result words out of output SRAM through a 2-entry skid buffer.
module conv_host_ctrl #(
    parameter int            AW        = 12,
    parameter int            DW        = 16,
    parameter logic [DW-1:0] TERM_WORD = 16'h00FF
) (
    input logic              clk,
    input logic              reset_b,
    conv_host_ctrl_if.master hif
);
    typedef enum logic [3:0] {
        S_IDLE, S_DIM, S_ROW, S_TERM, S_RUN, S_WAIT_HI, S_WAIT_LO, S_DRAIN, S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d, res_q, res_d, rptr_q, rptr_d, raddr_q, raddr_d, oidx_q, oidx_d;
    logic [4:0]    rows_q, rows_d;
    logic [DW-1:0] buf_q [2];
    logic [DW-1:0] buf_d [2];
    logic [1:0]    bcnt_q, bcnt_d;
    logic          bwr_q, bwr_d, brd_q, brd_d, pend_q, pend_d, err_q, err_d, done_q, done_d;

    logic fill_st, in_rdy, in_xfer, dim_ok, wfull, bad_word, rd_en, out_vld, is_last, pop;

    always_comb begin
        fill_st  = state_q inside {S_IDLE, S_DIM, S_ROW};
        in_rdy   = fill_st || state_q == S_ERR;
        in_xfer  = hif.in_valid && in_rdy;
        dim_ok   = hif.in_data[7:0] inside {8'd10, 8'd12, 8'd16};
        wfull    = &wptr_q;
        bad_word = 1'b0;
        if (state_q == S_ROW)
            bad_word = wfull || (hif.in_last && rows_q != 5'd1);
        else if (fill_st)
            bad_word = wfull || !dim_ok || hif.in_last;
        // Keep at most two words between the SRAM pipeline and the skid buffer.
        rd_en    = state_q == S_DRAIN && rptr_q != res_q && ({1'b0, bcnt_q} + {2'b0, pend_q}) < 3'd2;
        out_vld  = state_q == S_DRAIN && bcnt_q != 2'd0;
        is_last  = out_vld && oidx_q == res_q - 1'b1;
        pop      = out_vld && hif.out_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset_b) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DIM:
                if (in_xfer) state_d = bad_word ? (hif.in_last ? S_IDLE : S_ERR) : S_ROW;
            S_ROW:
                if (in_xfer) begin
                    if (bad_word)            state_d = hif.in_last ? S_IDLE : S_ERR;
                    else if (rows_q == 5'd1) state_d = hif.in_last ? S_TERM : S_DIM;
                end
            S_TERM:    state_d = S_RUN;
            S_RUN:     state_d = S_WAIT_HI;
            S_WAIT_HI: if (hif.dut_busy)  state_d = S_WAIT_LO;
            S_WAIT_LO: if (!hif.dut_busy) state_d = S_DRAIN;
            S_DRAIN:   if (pop && is_last) state_d = S_IDLE;
            S_ERR:     if (in_xfer && hif.in_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hif.in_ready                = in_rdy;
        hif.host_sram_write_enable  = (fill_st && in_xfer && !wfull) || state_q == S_TERM;
        hif.host_sram_write_address = wptr_q;
        hif.host_sram_write_data    = '0;
        if (state_q == S_TERM)                hif.host_sram_write_data = TERM_WORD;
        else if (hif.host_sram_write_enable) hif.host_sram_write_data = hif.in_data;
        hif.dut_run                 = state_q == S_RUN;
        hif.host_osram_read_address = rd_en ? rptr_q : raddr_q;
        hif.out_valid               = out_vld;
        hif.out_data                = out_vld ? buf_q[brd_q] : '0;
        hif.out_last                = is_last;
        hif.done                    = done_q;
        hif.err                     = err_q;
    end

    always_comb begin
        wptr_d  = wptr_q;
        res_d   = res_q;
        rows_d  = rows_q;
        rptr_d  = rptr_q;
        raddr_d = raddr_q;
        oidx_d  = oidx_q;
        buf_d   = buf_q;
        bwr_d   = bwr_q;
        brd_d   = brd_q;
        err_d   = err_q;
        pend_d  = rd_en;
        done_d  = pop && is_last;
        bcnt_d  = bcnt_q + {1'b0, pend_q} - {1'b0, pop};
        if (fill_st && in_xfer) begin
            if (bad_word) begin
                err_d = 1'b1;
                if (hif.in_last) begin
                    wptr_d = '0;
                    res_d  = '0;
                end
            end else begin
                wptr_d = wptr_q + 1'b1;
                if (state_q == S_ROW) begin
                    rows_d = rows_q - 5'd1;
                end else begin
                    rows_d = hif.in_data[4:0];
                    res_d  = res_q + AW'(hif.in_data[4:0]) - AW'(2);
                end
            end
        end
        if (state_q == S_TERM) wptr_d = wptr_q + 1'b1;
        if (state_q == S_ERR && in_xfer && hif.in_last) begin
            wptr_d = '0;
            res_d  = '0;
        end
        if (state_q == S_WAIT_LO && !hif.dut_busy) begin
            rptr_d = '0;
            oidx_d = '0;
        end
        if (rd_en) begin
            rptr_d  = rptr_q + 1'b1;
            raddr_d = rptr_q;
        end
        // SRAM data for a read issued last cycle lands now.
        if (pend_q) begin
            buf_d[bwr_q] = hif.osram_host_read_data;
            bwr_d        = ~bwr_q;
        end
        if (pop) begin
            brd_d  = ~brd_q;
            oidx_d = oidx_q + 1'b1;
        end
        if (pop && is_last) begin
            wptr_d = '0;
            res_d  = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            wptr_q   <= '0;
            res_q    <= '0;
            rows_q   <= '0;
            rptr_q   <= '0;
            raddr_q  <= '0;
            oidx_q   <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            bcnt_q   <= '0;
            bwr_q    <= 1'b0;
            brd_q    <= 1'b0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            res_q    <= res_d;
            rows_q   <= rows_d;
            rptr_q   <= rptr_d;
            raddr_q  <= raddr_d;
            oidx_q   <= oidx_d;
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            bcnt_q   <= bcnt_d;
            bwr_q    <= bwr_d;
            brd_q    <= brd_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_conv_host_ctrl.sv
// Directed bench for conv_host_ctrl: expected SRAM writes and result words are queued
// as stimulus is driven and popped by a negedge monitor as the controller produces them.
module tb_conv_host_ctrl;
    logic clk = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    conv_host_ctrl_if hif ();
    conv_host_ctrl dut (.clk(clk), .reset_b(reset_b), .hif(hif));

    typedef struct { logic [11:0] a; logic [15:0] d; } wr_t;
    typedef struct { logic [15:0] d; logic l; } ow_t;
    wr_t wq[$];
    ow_t oq[$];
    wr_t w_exp;
    ow_t o_exp;

    int checks = 0;
    int failures = 0;
    int run_cnt = 0, done_cnt = 0, ov_cnt = 0, wr_cnt = 0;
    logic [11:0] exp_wa = '0;
    logic        stall_q = 1'b0;
    logic [15:0] stall_d = '0;

    function automatic logic [15:0] oword(input logic [11:0] a);
        return 16'hC000 ^ {a[3:0], a};
    endfunction

    // Output SRAM model: registered read, data one cycle after the address.
    always @(posedge clk) hif.osram_host_read_data <= oword(hif.host_osram_read_address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_b) begin
            stall_q = 1'b0;
        end else begin
            if (hif.host_sram_write_enable) begin
                wr_cnt++;
                if (wq.size() > 0) begin
                    w_exp = wq.pop_front();
                    chk("wr_addr", 32'(hif.host_sram_write_address), 32'(w_exp.a));
                    chk("wr_data", 32'(hif.host_sram_write_data), 32'(w_exp.d));
                end else
                    chk("wr_unexpected", 32'(hif.host_sram_write_address), 32'hDEAD_BEEF);
            end
            if (hif.out_valid && hif.out_ready) begin
                if (oq.size() > 0) begin
                    o_exp = oq.pop_front();
                    chk("out_data", 32'(hif.out_data), 32'(o_exp.d));
                    chk("out_last", 32'(hif.out_last), 32'(o_exp.l));
                end else
                    chk("out_unexpected", 32'(hif.out_data), 32'hDEAD_BEEF);
            end
            if (stall_q) chk("stall_hold", 32'(hif.out_data), 32'(stall_d));
            stall_q = hif.out_valid && !hif.out_ready;
            stall_d = hif.out_data;
            if (hif.dut_run)   run_cnt++;
            if (hif.done)      done_cnt++;
            if (hif.out_valid) ov_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        run_cnt = 0; done_cnt = 0; ov_cnt = 0; wr_cnt = 0;
    endtask

    task automatic push_wr(input logic [15:0] d);
        wr_t w;
        w.a = exp_wa;
        w.d = d;
        wq.push_back(w);
        exp_wa++;
    endtask

    task automatic send(input logic [15:0] d, input logic l, input logic wr);
        logic ok;
        int k;
        ok = 1'b0;
        k = 0;
        hif.in_valid = 1'b1;
        hif.in_data  = d;
        hif.in_last  = l;
        if (wr) push_wr(d);
        while (!ok && k < 50) begin
            @(negedge clk);
            ok = hif.in_ready;
            tick();
            k++;
        end
        if (!ok) chk("in_ready_timeout", 32'(ok), 32'd1);
        hif.in_valid = 1'b0;
        hif.in_last  = 1'b0;
        hif.in_data  = '0;
    endtask

    task automatic send_mat(input logic [7:0] n, input logic last);
        send({8'h00, n}, 1'b0, 1'b1);
        for (int r = 0; r < int'(n); r++)
            send({n, 8'(r)}, last && r == int'(n) - 1, 1'b1);
    endtask

    task automatic wait_run();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = hif.dut_run;
        end
        chk("run_seen", 32'(seen), 32'd1);
        tick();
    endtask

    task automatic run_drain(input int nres, input int mode);
        logic seen;
        ow_t o;
        wait_run();
        for (int a = 0; a < nres; a++) begin
            o.d = oword(12'(a));
            o.l = (a == nres - 1);
            oq.push_back(o);
        end
        hif.dut_busy = 1'b1;
        repeat (3) tick();
        hif.dut_busy = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            if (mode == 0)   hif.out_ready = 1'b1;
            else if (k < 16) hif.out_ready = (k % 2 == 0);
            else if (k < 21) hif.out_ready = 1'b0;
            else             hif.out_ready = 1'b1;
            @(negedge clk);
            seen = hif.done;
            tick();
        end
        chk("done_seen", 32'(seen), 32'd1);
        hif.out_ready = 1'b1;
    endtask

    task automatic end_chk(input string t, input int runs, input int dones, input int wrs);
        chk({t, "_runs"}, 32'(run_cnt), 32'(runs));
        chk({t, "_dones"}, 32'(done_cnt), 32'(dones));
        chk({t, "_writes"}, 32'(wr_cnt), 32'(wrs));
        chk({t, "_wq_left"}, 32'(wq.size()), 32'd0);
        chk({t, "_oq_left"}, 32'(oq.size()), 32'd0);
    endtask

    initial begin
        hif.in_valid = 1'b0; hif.in_data = '0; hif.in_last = 1'b0;
        hif.dut_busy = 1'b0; hif.out_ready = 1'b1;
        repeat (3) tick();
        reset_b = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(hif.in_ready), 32'd1);
        chk("rst_we", 32'(hif.host_sram_write_enable), 32'd0);
        chk("rst_waddr", 32'(hif.host_sram_write_address), 32'd0);
        chk("rst_wdata", 32'(hif.host_sram_write_data), 32'd0);
        chk("rst_run", 32'(hif.dut_run), 32'd0);
        chk("rst_raddr", 32'(hif.host_osram_read_address), 32'd0);
        chk("rst_out_valid", 32'(hif.out_valid), 32'd0);
        chk("rst_done", 32'(hif.done), 32'd0);
        chk("rst_err", 32'(hif.err), 32'd0);
        tick();

        // 1) single 10x10 matrix
        clr_cnt(); exp_wa = '0;
        send_mat(8'd10, 1'b1);
        push_wr(16'h00FF);
        run_drain(8, 0);
        tick();
        end_chk("t1", 1, 1, 12);
        chk("t1_raddr_hold", 32'(hif.host_osram_read_address), 32'd7);

        // 2) 16, 12, 10 back to back, terminator at 41
        clr_cnt(); exp_wa = '0;
        send_mat(8'd16, 1'b0);
        send_mat(8'd12, 1'b0);
        send_mat(8'd10, 1'b1);
        push_wr(16'h00FF);
        run_drain(32, 0);
        tick();
        end_chk("t2", 1, 1, 42);

        // 3) bad dimension: stream discarded up to in_last
        clr_cnt(); exp_wa = '0;
        send(16'h000B, 1'b0, 1'b1);
        chk("t3_err", 32'(hif.err), 32'd1);
        for (int i = 0; i < 4; i++) send(16'h1230 + 16'(i), i == 3, 1'b0);
        @(negedge clk);
        chk("t3_idle_ready", 32'(hif.in_ready), 32'd1);
        repeat (5) tick();
        end_chk("t3", 0, 0, 1);
        chk("t3_err_sticky", 32'(hif.err), 32'd1);

        // 4) early in_last inside a 12x12 matrix
        reset_b = 1'b0;
        repeat (2) tick();
        reset_b = 1'b1;
        @(negedge clk);
        chk("t4_err_cleared", 32'(hif.err), 32'd0);
        tick();
        clr_cnt(); exp_wa = '0;
        send(16'h000C, 1'b0, 1'b1);
        for (int r = 0; r < 6; r++) send({8'h0C, 8'(r)}, r == 5, 1'b1);
        chk("t4_err", 32'(hif.err), 32'd1);
        @(negedge clk);
        chk("t4_idle_ready", 32'(hif.in_ready), 32'd1);
        repeat (5) tick();
        end_chk("t4", 0, 0, 7);

        // 5) drain under backpressure, stream restarts at address 0 after the error
        clr_cnt(); exp_wa = '0;
        send_mat(8'd16, 1'b0);
        send_mat(8'd16, 1'b1);
        push_wr(16'h00FF);
        run_drain(28, 1);
        tick();
        end_chk("t5", 1, 1, 35);

        // 6) reset while waiting for busy to fall
        clr_cnt(); exp_wa = '0;
        send_mat(8'd10, 1'b1);
        push_wr(16'h00FF);
        wait_run();
        hif.dut_busy = 1'b1;
        repeat (2) tick();
        reset_b = 1'b0;
        repeat (2) tick();
        reset_b = 1'b1;
        repeat (3) tick();
        hif.dut_busy = 1'b0;
        clr_cnt();
        repeat (20) tick();
        chk("t6_no_out_valid", 32'(ov_cnt), 32'd0);
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        chk("t6_no_run", 32'(run_cnt), 32'd0);
        chk("t6_err", 32'(hif.err), 32'd0);
        clr_cnt(); exp_wa = '0;
        send_mat(8'd10, 1'b1);
        push_wr(16'h00FF);
        run_drain(8, 0);
        tick();
        end_chk("t6", 1, 1, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
